// File: rtl/imm_gen_stage.sv
// Immediate generation stage: decodes RV32I/RV64I immediates and the
// PC-relative target, buffered in a small FIFO toward execute.
module imm_gen_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [31:0]                  inst_i,
  input  logic [DATA_WIDTH-1:0]        pc_i,
  input  logic                         flush_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_WIDTH-1:0]        imme_o,
  output logic [DATA_WIDTH-1:0]        pc_imm_o,
  output logic [2:0]                   imm_type_o,
  output logic                         illegal_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic IS64 = (DATA_WIDTH == 64);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_IMM32 = 7'h1b;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [6:0] OP_SYS   = 7'h73;
  localparam logic [6:0] OP_OP    = 7'h33;
  localparam logic [6:0] OP_OP32  = 7'h3b;
  localparam logic [6:0] OP_FENCE = 7'h0f;

  typedef enum logic [2:0] {
    T_NONE, T_I, T_S, T_B, T_U, T_J, T_Z, T_SH
  } imm_t;

  typedef struct packed {
    logic [DW-1:0] imm;
    logic [DW-1:0] pc_imm;
    imm_t          typ;
    logic          ill;
  } ent_t;

  function automatic logic [DW-1:0] sx(input logic [31:0] v);
    return DW'($signed(v));
  endfunction

  logic [6:0]    w_op;
  logic [2:0]    w_f3;
  logic          w_sh;
  logic [DW-1:0] w_imm;
  imm_t          w_typ;
  logic          w_ill;
  logic [DW-1:0] w_i;
  ent_t          w_ent;

  assign w_op = inst_i[6:0];
  assign w_f3 = inst_i[14:12];
  assign w_sh = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign w_i  = sx({{20{inst_i[31]}}, inst_i[31:20]});

  always_comb begin
    w_imm = '0;
    w_typ = T_NONE;
    w_ill = 1'b0;
    unique case (1'b1)
      w_op == OP_IMM: begin
        if (w_sh) begin
          w_typ = T_SH;
          w_imm = IS64 ? DW'(inst_i[25:20]) : DW'(inst_i[24:20]);
        end else begin
          w_typ = T_I;
          w_imm = w_i;
        end
      end
      (w_op == OP_LOAD) || (w_op == OP_JALR): begin
        w_typ = T_I;
        w_imm = w_i;
      end
      IS64 && (w_op == OP_IMM32): begin
        if (w_sh) begin
          w_typ = T_SH;
          w_imm = DW'(inst_i[24:20]);
        end else begin
          w_typ = T_I;
          w_imm = w_i;
        end
      end
      w_op == OP_STORE: begin
        w_typ = T_S;
        w_imm = sx({{20{inst_i[31]}}, inst_i[31:25],
                    inst_i[11:7]});
      end
      w_op == OP_BR: begin
        w_typ = T_B;
        w_imm = sx({{19{inst_i[31]}}, inst_i[31], inst_i[7],
                    inst_i[30:25], inst_i[11:8], 1'b0});
      end
      (w_op == OP_LUI) || (w_op == OP_AUIPC): begin
        w_typ = T_U;
        w_imm = sx({inst_i[31:12], 12'b0});
      end
      w_op == OP_JAL: begin
        w_typ = T_J;
        w_imm = sx({{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                    inst_i[20], inst_i[30:21], 1'b0});
      end
      w_op == OP_SYS: begin
        if (w_f3 != 3'b000) begin
          w_typ = T_Z;
          w_imm = DW'(inst_i[19:15]);
        end else begin
          w_typ = T_I;
          w_imm = w_i;
        end
      end
      (w_op == OP_OP) || (w_op == OP_FENCE) ||
      (IS64 && (w_op == OP_OP32)): begin
        w_typ = T_NONE;
      end
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_ent        = '0;
    w_ent.imm    = w_imm;
    w_ent.typ    = w_typ;
    w_ent.ill    = w_ill;
    if ((w_typ == T_B) || (w_typ == T_J) || (w_op == OP_AUIPC))
      w_ent.pc_imm = pc_i + w_imm;
  end

  ent_t          r_mem [DEPTH];
  ent_t          r_last;
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;
  ent_t          w_head;

  assign in_ready_o  = (r_cnt < FULL);
  assign out_valid_o = (r_cnt != '0);
  assign w_push = in_valid_i && in_ready_o && !flush_i;
  assign w_pop  = out_valid_o && out_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= w_ent;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_last <= '0;
    end else if (flush_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop) begin
        r_rp   <= r_rp + PW'(1);
        r_last <= r_mem[r_rp];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Empty FIFO shows the last popped entry, not a stale slot.
  assign w_head     = out_valid_o ? r_mem[r_rp] : r_last;
  assign imme_o     = w_head.imm;
  assign pc_imm_o   = w_head.pc_imm;
  assign imm_type_o = w_head.typ;
  assign illegal_o  = w_head.ill;
  assign count_o    = r_cnt;

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage for the RV64I/RV32I decode path. It accepts an instruction and its PC over a valid/ready handshake and decodes all immediate formats with correct sign extension, including shift amounts and CSR zimm. It also computes the PC-relative target, classifies the format, and holds results in a DEPTH-entry FIFO so decode can run ahead of a stalled execute stage.

## Interface
- DATA_WIDTH, 64, datapath width; legal values 32 or 64
- DEPTH, 2, FIFO entries; power of two, ≥2
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- in_valid_i  input  1  instruction valid
- in_ready_o  output  1  stage can accept
- inst_i  input  32  instruction word
- pc_i  input  DATA_WIDTH  instruction PC
- flush_i  input  1  discard all buffered entries
- out_valid_o  output  1  head entry valid
- out_ready_i  input  1  consumer accepts head
- imme_o  output  DATA_WIDTH  decoded immediate
- pc_imm_o  output  DATA_WIDTH  pc + immediate for B/J/AUIPC, else 0
- imm_type_o  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 SHAMT
- illegal_o  output  1  opcode not recognised
- count_o  output  $clog2(DEPTH+1)  current occupancy

## Operation
- Decode runs at FIFO write. Each entry stores imme, pc_imm, imm_type and illegal.
- OP-IMM (0x13), LOAD (0x03), JALR (0x67), and OP-IMM-32 (0x1b, DATA_WIDTH=64 only):
  - I type: sign-extend inst[31:20].
  - Exception, OP-IMM with funct3 001/101: SHAMT type. Zero-extend inst[25:20] when DATA_WIDTH=64, inst[24:20] when 32.
  - Exception, OP-IMM-32 with funct3 001/101: SHAMT type, zero-extend inst[24:20].
- STORE (0x23): S type, sign-extend {inst[31:25], inst[11:7]}.
- BRANCH (0x63): B type, sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
- LUI (0x37), AUIPC (0x17): U type, {inst[31:12], 12'b0} sign-extended from bit 31.
- JAL (0x6f): J type, sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
- SYSTEM (0x73):
  - funct3≠000: Z type, zero-extend inst[19:15].
  - funct3=000: I type.
- OP (0x33), OP-32 (0x3b, DATA_WIDTH=64 only), FENCE (0x0f): NONE type, imm 0, illegal 0.
- Any other opcode, inst[1:0]≠2'b11, or a 64-only opcode when DATA_WIDTH=32: NONE type, imm 0, illegal 1.
- pc_imm = pc_i + imm, modulo 2^DATA_WIDTH, for B, J and AUIPC; 0 for all others.

## Timing
- Reset (async, rst_n_i low):
  - count_o=0, out_valid_o=0, in_ready_o=1.
  - imme_o, pc_imm_o, imm_type_o and illegal_o are all 0.
  - Pointers cleared; takes effect immediately, mid-transfer included.
- Accept when in_valid_i && in_ready_o. in_ready_o = (count < DEPTH), from registered count only, never from out_ready_i.
- Full: in_ready_o=0. A push is refused even if a pop occurs in the same cycle.
- Latency: an entry accepted at edge N is visible on the outputs after edge N (1 cycle). No combinational in→out path.
- out_valid_o = (count ≠ 0). Outputs show the head entry. Pop when out_valid_o && out_ready_i.
- Outputs are stable while out_valid_o && !out_ready_i. When empty, outputs hold the last popped values.
- Simultaneous push and pop when not full: count unchanged, order preserved.
- Pointer wrap-around: modulo DEPTH.
- flush_i has priority. On the next edge count=0, out_valid_o=0, and any push or pop in that same cycle is discarded. in_ready_o in the flush cycle reflects the pre-flush count.

## Test plan
- DATA_WIDTH=64: push inst 0xfff00093 (addi -1), pc 0 → next cycle out_valid_o=1, imme_o=0xFFFF_FFFF_FFFF_FFFF, imm_type_o=1, illegal_o=0.
- Push 0xfe000ee3 (beq -4) at pc 0x1000 → imme_o=0xFFFF_FFFF_FFFF_FFFC, pc_imm_o=0x0000_0000_0000_0FFC, imm_type_o=3.
- Push sequence:
  - 0x800000b7 (lui 0x80000) → imme_o=0xFFFF_FFFF_8000_0000, type 4.
  - 0x03f09093 (slli 63) → imme_o=63, type 7.
  - 0x0007d073 (csrrwi zimm=15) → imme_o=15, type 6.
  - 0x00000000 → illegal_o=1, imme_o=0.
- DEPTH=2, out_ready_i=0: present 3 instructions back-to-back → in_ready_o=0 after 2 accepts, count_o=2, third held. Raise out_ready_i → all 3 emerge in order, one per cycle.
- count_o=2, flush_i=1 with in_valid_i=1 in the same cycle → next cycle count_o=0, out_valid_o=0, the presented instruction is not stored.
- Assert rst_n_i asynchronously mid-stream with count_o=1 → outputs clear before the next clock edge. After release, in_ready_o=1 and out_valid_o=0.
